// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants.
package mips_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and redirect.
interface fetch_unit_if
    import mips_pkg::*;
();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] instr_pc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instruction, instr_pc,
        input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
        output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with registered storage; a push alongside a pop is accepted even when full.
module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_pop, do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = next_ptr(wr_q);
            if (do_pop)  rd_d = next_ptr(rd_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && do_push) mem_q[wr_q] <= data_i;
    end

    // Upstream credit accounting must never let a lone push reach a full queue.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i) assert (!(push_i && full && !do_pop));
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read credits, wrong-path discard and the decode queue.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   q_count, tag_count;
    logic [XLEN-1:0] tag_head;
    fetch_entry_t    q_head, q_entry;
    logic            credit_ok, req, rsp, q_push, xfer, valid;

    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, q_count}) < (CW + 1)'(DEPTH);
    assign req       = rst_n && !bus.redirect && credit_ok;
    assign rsp       = rst_n && bus.imem_rvalid;
    assign q_push    = rsp && !bus.redirect && (discard_q == '0);
    assign valid     = (q_count != '0);
    assign xfer      = valid && bus.instr_ready && !bus.redirect;

    assign q_entry.pc    = tag_head;
    assign q_entry.instr = bus.imem_rdata;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req) - CW'(rsp);
        discard_d     = discard_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight belongs to the old path.
            discard_d  = outstanding_q - CW'(rsp);
        end else begin
            if (req) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (rsp && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (tag_count == outstanding_q);
            assert (discard_q <= outstanding_q);
        end
    end

    fetch_queue #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.redirect),
        .push_i  (q_push),
        .pop_i   (xfer),
        .data_i  (q_entry),
        .head_o  (q_head),
        .count_o (q_count)
    );

    // Tag FIFO is never flushed: discarded responses still pop their tags.
    fetch_queue #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req),
        .pop_i   (rsp),
        .data_i  (fetch_pc_q),
        .head_o  (tag_head),
        .count_o (tag_count)
    );

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = valid;
    assign bus.instruction = valid ? q_head.instr : NOP_INSTR;
    assign bus.instr_pc    = valid ? q_head.pc : '0;
endmodule
